adventure_game_ctrl: RTL and testbench

- Front-end controller for the adventure-game room state machine.
- Synchronises and edge-detects raw direction and restart buttons, and issues single-cycle, one-hot move pulses (n/s/e/w) to the room FSM.
- Holds the vorpal-sword flag (v), counts moves, enforces a move limit and sequences game start and restart, including the room FSM's reset.
- Sits between board buttons and the room FSM, whose outputs (sw, win, d) it consumes.

---
 rtl/adventure_game_ctrl_pkg.sv | 9 +
 rtl/adventure_game_ctrl_if.sv | 20 ++
 rtl/adventure_game_ctrl_btn_edge_sync.sv | 24 ++
 rtl/adventure_game_ctrl.sv | 132 +++++++++++++
 tb/tb_adventure_game_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/adventure_game_ctrl_pkg.sv
// Shared types and default sizing for the adventure-game front-end controller.
// Pure declarations; no logic, latency or flow control of its own.
package adv_pkg;
  typedef enum logic [2:0] {INIT, PLAY, SETTLE, WON, DEAD, TIMEOUT} ctrl_state_e;
  typedef enum logic [1:0] {N, S, E, W} dir_e;

  localparam int DEF_MAX_MOVES       = 15;
  localparam int DEF_ROOM_RST_CYCLES = 2;
endpackage

// File: rtl/adventure_game_ctrl_if.sv
// Button, room-FSM and status signals of the controller; master = controller side.
// Wires only; no latency; no backpressure (pulses are fire-and-forget).
interface adventure_game_ctrl_if #(parameter int CNT_W = 8);
  logic             btn_n, btn_s, btn_e, btn_w, btn_restart;
  logic             room_sw, room_win, room_d;
  logic             room_rst;
  logic             mv_n, mv_s, mv_e, mv_w;
  logic             v;
  logic [CNT_W-1:0] move_cnt;
  logic             playing, won, dead, timeout;

  modport master (
    input  btn_n, btn_s, btn_e, btn_w, btn_restart, room_sw, room_win, room_d,
    output room_rst, mv_n, mv_s, mv_e, mv_w, v, move_cnt, playing, won, dead, timeout
  );
  modport slave (
    output btn_n, btn_s, btn_e, btn_w, btn_restart, room_sw, room_win, room_d,
    input  room_rst, mv_n, mv_s, mv_e, mv_w, v, move_cnt, playing, won, dead, timeout
  );
endinterface

// File: rtl/adventure_game_ctrl_btn_edge_sync.sv
// 2-flop synchroniser plus registered rising-edge pulse for one raw button.
// Pulse is high for one cycle after the 3rd clk edge following the raw rise; no backpressure.
module btn_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic rise
);
  logic meta, sync, sync_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta   <= raw;
      sync   <= meta;
      sync_d <= sync;
      rise   <= sync & ~sync_d;
    end
  end
endmodule

// File: rtl/adventure_game_ctrl.sv
// Game sequencer in front of the room FSM: button sync, one-hot move pulses, sword flag, move limit.
// Move pulse 4 clk edges after a raw press; ADV_AUTO_RESTART_EN adds a timed return from terminal states.
module adventure_game_ctrl
  import adv_pkg::*;
#(
  parameter int MAX_MOVES       = DEF_MAX_MOVES,
  parameter int ROOM_RST_CYCLES = DEF_ROOM_RST_CYCLES,
  parameter int CNT_W           = 8
`ifdef ADV_AUTO_RESTART_EN
  ,
  parameter int HOLD_CYCLES     = 1000
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  adventure_game_ctrl_if.master bus
);
  localparam int RST_W = $clog2(ROOM_RST_CYCLES + 1);

  ctrl_state_e      state, state_nxt;
  logic [3:0]       dir_edge, mv_q, mv_nxt;
  logic             restart_edge;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             v_q, v_nxt;
  logic [RST_W-1:0] init_cnt, init_nxt;
`ifdef ADV_AUTO_RESTART_EN
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
`endif

  btn_edge_sync u_sync_n (.clk(clk), .reset_n(reset_n), .raw(bus.btn_n),       .rise(dir_edge[N]));
  btn_edge_sync u_sync_s (.clk(clk), .reset_n(reset_n), .raw(bus.btn_s),       .rise(dir_edge[S]));
  btn_edge_sync u_sync_e (.clk(clk), .reset_n(reset_n), .raw(bus.btn_e),       .rise(dir_edge[E]));
  btn_edge_sync u_sync_w (.clk(clk), .reset_n(reset_n), .raw(bus.btn_w),       .rise(dir_edge[W]));
  btn_edge_sync u_sync_r (.clk(clk), .reset_n(reset_n), .raw(bus.btn_restart), .rise(restart_edge));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT;
      mv_q     <= '0;
      cnt_q    <= '0;
      v_q      <= 1'b0;
      init_cnt <= '0;
`ifdef ADV_AUTO_RESTART_EN
      hold_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      mv_q     <= mv_nxt;
      cnt_q    <= cnt_nxt;
      v_q      <= v_nxt;
      init_cnt <= init_nxt;
`ifdef ADV_AUTO_RESTART_EN
      hold_cnt <= hold_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    mv_nxt    = '0;
    cnt_nxt   = cnt_q;
    v_nxt     = v_q;
    init_nxt  = '0;
`ifdef ADV_AUTO_RESTART_EN
    hold_nxt  = '0;
`endif
    case (state)
      INIT: begin
        if (init_cnt == RST_W'(ROOM_RST_CYCLES - 1)) state_nxt = PLAY;
        else                                          init_nxt  = init_cnt + 1'b1;
      end
      PLAY: begin
        if (bus.room_sw) v_nxt = 1'b1;
        // Room-driven outcomes pre-empt a move; restart pre-empts everything.
        if (restart_edge) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
          v_nxt     = 1'b0;
        end else if (bus.room_win) begin
          state_nxt = WON;
        end else if (bus.room_d) begin
          state_nxt = DEAD;
        end else if ($onehot(dir_edge)) begin
          mv_nxt    = dir_edge;
          state_nxt = SETTLE;
          if (cnt_q != CNT_W'(MAX_MOVES)) cnt_nxt = cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        if (bus.room_sw) v_nxt = 1'b1;
        if (restart_edge) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
          v_nxt     = 1'b0;
        end else if (bus.room_win)              state_nxt = WON;
        else if (bus.room_d)                    state_nxt = DEAD;
        else if (cnt_q == CNT_W'(MAX_MOVES))    state_nxt = TIMEOUT;
        else                                    state_nxt = PLAY;
      end
      default: begin
        if (restart_edge) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
          v_nxt     = 1'b0;
        end
`ifdef ADV_AUTO_RESTART_EN
        else if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
          v_nxt     = 1'b0;
        end else begin
          hold_nxt  = hold_cnt + 1'b1;
        end
`endif
      end
    endcase
  end

  // Room reset also follows reset_n directly so the room FSM clears without a clock.
  assign bus.room_rst = ~reset_n | (state == INIT);
  assign bus.mv_n     = mv_q[N];
  assign bus.mv_s     = mv_q[S];
  assign bus.mv_e     = mv_q[E];
  assign bus.mv_w     = mv_q[W];
  assign bus.v        = v_q;
  assign bus.move_cnt = cnt_q;
  assign bus.playing  = (state == PLAY) || (state == SETTLE);
  assign bus.won      = (state == WON);
  assign bus.dead     = (state == DEAD);
  assign bus.timeout  = (state == TIMEOUT);
endmodule

// File: tb/tb_adventure_game_ctrl.sv
// Directed bench for adventure_game_ctrl; room FSM outputs are driven by hand like a Moore room.
// Move vectors are {n,s,e,w}.
module tb_adventure_game_ctrl;
  localparam int MAXM = 6;
  localparam logic [3:0] DN = 4'b1000, DS = 4'b0100, DE = 4'b0010, DW = 4'b0001, D0 = 4'b0000;

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  adventure_game_ctrl_if #(.CNT_W(8)) bus ();

  adventure_game_ctrl #(
    .MAX_MOVES(MAXM),
    .ROOM_RST_CYCLES(2),
    .CNT_W(8)
`ifdef ADV_AUTO_RESTART_EN
    ,
    .HOLD_CYCLES(10)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] mv_vec();
    return {bus.mv_n, bus.mv_s, bus.mv_e, bus.mv_w};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press and release a direction set; the pulse must show on the 4th edge and only once.
  task automatic press(input string tag, input logic [3:0] dir, input logic [3:0] exp);
    logic [3:0] at4;
    int pulses;
    at4    = '0;
    pulses = 0;
    {bus.btn_n, bus.btn_s, bus.btn_e, bus.btn_w} = dir;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 4) at4 = mv_vec();
      if (mv_vec() != 4'b0) pulses++;
    end
    {bus.btn_n, bus.btn_s, bus.btn_e, bus.btn_w} = 4'b0;
    tick(4);
    check($sformatf("%s pulse", tag), int'(at4), int'(exp));
    check($sformatf("%s npulse", tag), pulses, (exp != 4'b0) ? 1 : 0);
  endtask

  // Restart (optionally with a simultaneous E press); room held in reset for exactly 2 cycles.
  task automatic restart(input string tag, input logic with_e);
    int rst_cyc;
    int pulses;
    rst_cyc = 0;
    pulses  = 0;
    bus.room_sw = 1'b0; bus.room_win = 1'b0; bus.room_d = 1'b0;
    bus.btn_restart = 1'b1;
    bus.btn_e       = with_e;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (bus.room_rst) rst_cyc++;
      if (mv_vec() != 4'b0) pulses++;
    end
    bus.btn_restart = 1'b0;
    bus.btn_e       = 1'b0;
    tick(4);
    check($sformatf("%s room_rst cycles", tag), rst_cyc, 2);
    check($sformatf("%s pulses", tag), pulses, 0);
    check($sformatf("%s playing", tag), int'(bus.playing), 1);
    check($sformatf("%s move_cnt", tag), int'(bus.move_cnt), 0);
    check($sformatf("%s v", tag), int'(bus.v), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    {bus.btn_n, bus.btn_s, bus.btn_e, bus.btn_w, bus.btn_restart} = '0;
    {bus.room_sw, bus.room_win, bus.room_d} = '0;
    tick(2);
    check("rst room_rst", int'(bus.room_rst), 1);
    check("rst mv", int'(mv_vec()), 0);
    check("rst move_cnt", int'(bus.move_cnt), 0);
    check("rst v", int'(bus.v), 0);
    check("rst status", int'({bus.playing, bus.won, bus.dead, bus.timeout}), 0);
    reset_n = 1'b1;
    check("init room_rst", int'(bus.room_rst), 1);
    tick(2);
    check("init done playing", int'(bus.playing), 1);
    check("init done room_rst", int'(bus.room_rst), 0);

    // Win path: sword picked up after the W move.
    press("win E1", DE, DE);
    press("win S", DS, DS);
    check("win v before sword", int'(bus.v), 0);
    press("win W", DW, DW);
    bus.room_sw = 1'b1;
    tick(1);
    bus.room_sw = 1'b0;
    check("win v set", int'(bus.v), 1);
    press("win E2", DE, DE);
    press("win E3", DE, DE);
    check("win move_cnt", int'(bus.move_cnt), 5);
    bus.room_win = 1'b1;
    tick(1);
    check("win won", int'(bus.won), 1);
    check("win playing", int'(bus.playing), 0);
    press("won N ignored", DN, D0);
    check("won held", int'(bus.won), 1);
    check("won v sticky", int'(bus.v), 1);
    restart("after win", 1'b0);

    // Death path without sword.
    press("dead E", DE, DE);
    press("dead S", DS, DS);
    press("dead E2", DE, DE);
    bus.room_d = 1'b1;
    tick(1);
    check("dead dead", int'(bus.dead), 1);
    check("dead move_cnt", int'(bus.move_cnt), 3);
    check("dead v", int'(bus.v), 0);
    press("dead N ignored", DN, D0);
    check("dead held", int'(bus.dead), 1);
    restart("after dead", 1'b0);

    // Simultaneous edges are illegal, then a mid-game restart racing an E press.
    press("simul ES", DE | DS, D0);
    check("simul move_cnt", int'(bus.move_cnt), 0);
    check("simul playing", int'(bus.playing), 1);
    press("lone E", DE, DE);
    check("lone E move_cnt", int'(bus.move_cnt), 1);
    press("mid W", DW, DW);
    bus.room_sw = 1'b1;
    tick(1);
    bus.room_sw = 1'b0;
    check("mid v", int'(bus.v), 1);
    check("mid move_cnt", int'(bus.move_cnt), 2);
    restart("midgame", 1'b1);

    // Move limit: MAXM moves end the game; further presses do nothing.
    for (int i = 1; i <= MAXM; i++) begin
      press($sformatf("limit %0d", i), (i % 2 == 1) ? DE : DW, (i % 2 == 1) ? DE : DW);
      if (i == MAXM - 1) check("limit not yet", int'(bus.timeout), 0);
    end
    check("limit timeout", int'(bus.timeout), 1);
    check("limit move_cnt", int'(bus.move_cnt), MAXM);
    check("limit playing", int'(bus.playing), 0);
    press("limit extra E", DE, D0);
    check("limit saturated", int'(bus.move_cnt), MAXM);
    restart("after timeout", 1'b0);

`ifdef ADV_AUTO_RESTART_EN
    begin
      int won_cyc;
      press("auto E", DE, DE);
      bus.room_win = 1'b1;
      tick(1);
      check("auto won", int'(bus.won), 1);
      bus.room_win = 1'b0;
      won_cyc = 1;
      for (int i = 0; i < 20; i++) begin
        tick(1);
        if (!bus.won) break;
        won_cyc++;
      end
      check("auto hold cycles", won_cyc, 10);
      check("auto room_rst", int'(bus.room_rst), 1);
      tick(2);
      check("auto playing", int'(bus.playing), 1);
      check("auto move_cnt", int'(bus.move_cnt), 0);
    end
`endif

    // Asynchronous reset while a move pulse is high.
    bus.btn_e = 1'b1;
    tick(4);
    check("areset pulse up", int'(mv_vec()), int'(DE));
    #1 reset_n = 1'b0;
    #1;
    check("areset mv_e", int'(bus.mv_e), 0);
    check("areset room_rst", int'(bus.room_rst), 1);
    check("areset move_cnt", int'(bus.move_cnt), 0);
    bus.btn_e = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check("areset recover playing", int'(bus.playing), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
